// File: rtl/sdram_arbiter_if.sv
// Master-side and controller-side signals of the three-master SDRAM arbiter.
// The slave modport is the arbiter's view; master is the surrounding system's view.
interface sdram_arbiter_if;
  logic        m0_valid, m1_valid, m2_valid;
  logic        m0_ready, m1_ready, m2_ready;
  logic [25:0] m0_address, m1_address, m2_address;
  logic        m0_write, m1_write, m2_write;
  logic        m0_burst, m1_burst, m2_burst;
  logic [3:0]  m0_wstrb, m1_wstrb, m2_wstrb;
  logic [31:0] m0_wdata, m1_wdata, m2_wdata;
  logic        m0_rvalid, m1_rvalid, m2_rvalid;
  logic        m0_complete, m1_complete, m2_complete;
  logic [31:0] m_rdata;
  logic [8:0]  m_rtag;

  logic [2:0]  sdram_request;
  logic        sdram_ready;
  logic [25:0] sdram_address;
  logic        sdram_write;
  logic        sdram_burst;
  logic [3:0]  sdram_wstrb;
  logic [31:0] sdram_wdata;
  logic [31:0] sdram_rdata;
  logic [8:0]  sdram_rtag;
  logic [2:0]  sdram_rvalid;
  logic        sdram_complete;
  logic        protocol_error;

  modport slave (
    input  m0_valid, m1_valid, m2_valid,
    input  m0_address, m1_address, m2_address,
    input  m0_write, m1_write, m2_write,
    input  m0_burst, m1_burst, m2_burst,
    input  m0_wstrb, m1_wstrb, m2_wstrb,
    input  m0_wdata, m1_wdata, m2_wdata,
    output m0_ready, m1_ready, m2_ready,
    output m0_rvalid, m1_rvalid, m2_rvalid,
    output m0_complete, m1_complete, m2_complete,
    output m_rdata, m_rtag,
    output sdram_request, sdram_address, sdram_write, sdram_burst, sdram_wstrb, sdram_wdata,
    input  sdram_ready, sdram_rdata, sdram_rtag, sdram_rvalid, sdram_complete,
    output protocol_error
  );

  modport master (
    output m0_valid, m1_valid, m2_valid,
    output m0_address, m1_address, m2_address,
    output m0_write, m1_write, m2_write,
    output m0_burst, m1_burst, m2_burst,
    output m0_wstrb, m1_wstrb, m2_wstrb,
    output m0_wdata, m1_wdata, m2_wdata,
    input  m0_ready, m1_ready, m2_ready,
    input  m0_rvalid, m1_rvalid, m2_rvalid,
    input  m0_complete, m1_complete, m2_complete,
    input  m_rdata, m_rtag,
    input  sdram_request, sdram_address, sdram_write, sdram_burst, sdram_wstrb, sdram_wdata,
    output sdram_ready, sdram_rdata, sdram_rtag, sdram_rvalid, sdram_complete,
    input  protocol_error
  );
endinterface

// File: rtl/sdram_arbiter.sv
// Three-master round-robin arbiter in front of sdram_controller: one request slot per
// master, issue one cycle after capture, read responses routed back one cycle late.
module sdram_arbiter (
  input  logic           clock,
  input  logic           reset,
  sdram_arbiter_if.slave bus
);
  typedef enum logic {IDLE, ISSUE} state_t;

  typedef struct packed {
    logic [25:0] address;
    logic        write;
    logic        burst;
    logic [3:0]  wstrb;
    logic [31:0] wdata;
  } req_t;

  state_t      state;
  logic [1:0]  grant_id;
  logic [1:0]  rr_ptr;
  logic [2:0]  req_q;
  req_t        out_q;
  req_t        slot [3];
  req_t        in_req [3];
  logic [2:0]  slot_valid;
  logic [2:0]  in_valid;
  logic [2:0]  cand;
  logic        pick_vld;
  logic [1:0]  pick_id;
  logic [1:0]  scan;
  logic        accept;
  logic        push;
  logic        pop;

  logic [1:0]  fifo_mem [4];
  logic [1:0]  wr_ptr;
  logic [1:0]  rd_ptr;
  logic [2:0]  fifo_cnt;
  logic        fifo_full;

  logic [2:0]  rvalid_q;
  logic [2:0]  complete_q;
  logic [31:0] rdata_q;
  logic [8:0]  rtag_q;
  logic        perr_q;
  logic        rvalid_multi;

  function automatic logic [1:0] next_id(input logic [1:0] id);
    return (id == 2'd2) ? 2'd0 : id + 2'd1;
  endfunction

  always_comb begin
    in_valid  = {bus.m2_valid, bus.m1_valid, bus.m0_valid};
    in_req[0] = {bus.m0_address, bus.m0_write, bus.m0_burst, bus.m0_wstrb, bus.m0_wdata};
    in_req[1] = {bus.m1_address, bus.m1_write, bus.m1_burst, bus.m1_wstrb, bus.m1_wdata};
    in_req[2] = {bus.m2_address, bus.m2_write, bus.m2_burst, bus.m2_wstrb, bus.m2_wdata};
  end

  assign accept       = (req_q != 3'b000) && bus.sdram_ready;
  assign push         = accept && !out_q.write;
  assign pop          = bus.sdram_complete && (fifo_cnt != 3'd0);
  assign fifo_full    = (fifo_cnt == 3'd4);
  assign rvalid_multi = (bus.sdram_rvalid & (bus.sdram_rvalid - 3'd1)) != 3'd0;

  // Reads are held back while the return-order FIFO has no room; writes never are.
  always_comb begin
    cand     = '0;
    pick_vld = 1'b0;
    pick_id  = rr_ptr;
    scan     = rr_ptr;
    for (int i = 0; i < 3; i++) begin
      cand[i] = slot_valid[i] && (slot[i].write || !fifo_full);
    end
    for (int k = 0; k < 3; k++) begin
      if (!pick_vld && cand[scan]) begin
        pick_vld = 1'b1;
        pick_id  = scan;
      end
      scan = next_id(scan);
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      slot_valid <= '0;
      for (int i = 0; i < 3; i++) slot[i] <= '0;
    end else begin
      for (int i = 0; i < 3; i++) begin
        if (in_valid[i] && !slot_valid[i]) begin
          slot_valid[i] <= 1'b1;
          slot[i]       <= in_req[i];
        end else if (accept && grant_id == 2'(i)) begin
          slot_valid[i] <= 1'b0;
        end
      end
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state    <= IDLE;
      grant_id <= 2'd0;
      rr_ptr   <= 2'd0;
      req_q    <= 3'b000;
      out_q    <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (pick_vld) begin
            grant_id <= pick_id;
            req_q    <= 3'b001 << pick_id;
            out_q    <= slot[pick_id];
            state    <= ISSUE;
          end
        end
        ISSUE: begin
          if (accept) begin
            req_q  <= 3'b000;
            rr_ptr <= next_id(grant_id);
            state  <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      wr_ptr   <= 2'd0;
      rd_ptr   <= 2'd0;
      fifo_cnt <= 3'd0;
      for (int i = 0; i < 4; i++) fifo_mem[i] <= 2'd0;
    end else begin
      if (push) begin
        fifo_mem[wr_ptr] <= grant_id;
        wr_ptr           <= wr_ptr + 2'd1;
      end
      if (pop) rd_ptr <= rd_ptr + 2'd1;
      if (push && !pop)      fifo_cnt <= fifo_cnt + 3'd1;
      else if (pop && !push) fifo_cnt <= fifo_cnt - 3'd1;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      rvalid_q   <= 3'b000;
      complete_q <= 3'b000;
      rdata_q    <= 32'd0;
      rtag_q     <= 9'd0;
      perr_q     <= 1'b0;
    end else begin
      rvalid_q   <= bus.sdram_rvalid;
      rdata_q    <= bus.sdram_rdata;
      rtag_q     <= bus.sdram_rtag;
      complete_q <= pop ? (3'b001 << fifo_mem[rd_ptr]) : 3'b000;
      if ((bus.sdram_complete && fifo_cnt == 3'd0) || rvalid_multi) perr_q <= 1'b1;
    end
  end

  assign bus.m0_ready       = !slot_valid[0];
  assign bus.m1_ready       = !slot_valid[1];
  assign bus.m2_ready       = !slot_valid[2];
  assign bus.m0_rvalid      = rvalid_q[0];
  assign bus.m1_rvalid      = rvalid_q[1];
  assign bus.m2_rvalid      = rvalid_q[2];
  assign bus.m0_complete    = complete_q[0];
  assign bus.m1_complete    = complete_q[1];
  assign bus.m2_complete    = complete_q[2];
  assign bus.m_rdata        = rdata_q;
  assign bus.m_rtag         = rtag_q;
  assign bus.sdram_request  = req_q;
  assign bus.sdram_address  = out_q.address;
  assign bus.sdram_write    = out_q.write;
  assign bus.sdram_burst    = out_q.burst;
  assign bus.sdram_wstrb    = out_q.wstrb;
  assign bus.sdram_wdata    = out_q.wdata;
  assign bus.protocol_error = perr_q;
endmodule

// File: tb/tb_sdram_arbiter.sv
// Bench for sdram_arbiter: directed scenarios plus randomized traffic, checked by
// scoreboards fed at stimulus time and drained by monitors on DUT outputs.
module tb_sdram_arbiter;
  typedef struct packed {
    logic [25:0] a;
    logic        w;
    logic        b;
    logic [3:0]  s;
    logic [31:0] d;
  } req_t;
  typedef struct packed { logic [1:0] id; req_t r; } pend_t;
  typedef struct packed { logic [1:0] id; logic b; } rd_t;
  typedef struct packed { logic [2:0] mask; logic [31:0] data; logic [8:0] tag; } rsp_t;

  logic clock;
  logic reset;
  sdram_arbiter_if bus ();
  sdram_arbiter dut (.clock(clock), .reset(reset), .bus(bus.slave));

  int         vectors = 0;
  int         miscompares = 0;
  pend_t      exp_q[$];
  rd_t        ref_rd_q[$];
  rsp_t       rsp_q[$];
  logic [2:0] cmp_q[$];
  logic [1:0] grant_log[$];
  logic       exp_perr;
  bit         rnd_done;

  initial clock = 1'b0;
  always #5 clock = ~clock;

  initial begin
    #800000;
    $display("FAIL watchdog: time limit reached, vectors=%0d", vectors);
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic fail(input string name, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    miscompares++;
    $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
  endtask

  task automatic set_m(input int n, input logic v, input req_t r);
    case (n)
      0: begin bus.m0_valid = v; bus.m0_address = r.a; bus.m0_write = r.w; bus.m0_burst = r.b; bus.m0_wstrb = r.s; bus.m0_wdata = r.d; end
      1: begin bus.m1_valid = v; bus.m1_address = r.a; bus.m1_write = r.w; bus.m1_burst = r.b; bus.m1_wstrb = r.s; bus.m1_wdata = r.d; end
      default: begin bus.m2_valid = v; bus.m2_address = r.a; bus.m2_write = r.w; bus.m2_burst = r.b; bus.m2_wstrb = r.s; bus.m2_wdata = r.d; end
    endcase
  endtask

  function automatic logic get_rdy(input int n);
    case (n)
      0:       return bus.m0_ready;
      1:       return bus.m1_ready;
      default: return bus.m2_ready;
    endcase
  endfunction

  function automatic req_t rnd_req(input logic w);
    req_t r;
    r.a = 26'($urandom);
    r.w = w;
    r.b = w ? 1'b0 : 1'($urandom_range(0, 1));
    r.s = 4'($urandom);
    r.d = $urandom;
    return r;
  endfunction

  function automatic logic [63:0] glog();
    logic [63:0] v = '0;
    foreach (grant_log[i]) v = (v << 4) | 64'(grant_log[i]);
    return v;
  endfunction

  // Offer r on master n until the slot takes it; called and returns at posedge+1.
  task automatic send(input int n, input req_t r);
    bit ok = 1'b0;
    set_m(n, 1'b1, r);
    for (int t = 0; t < 400 && !ok; t++) begin
      @(negedge clock);
      if (get_rdy(n)) begin
        ok = 1'b1;
        exp_q.push_back({2'(n), r});
      end
      @(posedge clock); #1;
    end
    set_m(n, 1'b0, '0);
    if (!ok) fail($sformatf("send_timeout_m%0d", n), 64'(ok), 64'd1);
  endtask

  task automatic pulse_rvalid(input logic [2:0] mask, input logic [31:0] d, input logic [8:0] tag);
    bus.sdram_rvalid = mask;
    bus.sdram_rdata  = d;
    bus.sdram_rtag   = tag;
    rsp_q.push_back({mask, d, tag});
    @(posedge clock); #1;
    bus.sdram_rvalid = 3'b000;
  endtask

  // The oldest accepted read completes; an empty reference FIFO means a protocol error.
  task automatic pulse_complete();
    rd_t h;
    bus.sdram_complete = 1'b1;
    if (ref_rd_q.size() == 0) exp_perr = 1'b1;
    else begin
      h = ref_rd_q.pop_front();
      cmp_q.push_back(3'b001 << h.id);
    end
    @(posedge clock); #1;
    bus.sdram_complete = 1'b0;
  endtask

  task automatic respond();
    rd_t h = ref_rd_q[0];
    int  len = h.b ? 16 : 1;
    for (int k = 0; k < len; k++) pulse_rvalid(3'b001 << h.id, $urandom, 9'($urandom));
    pulse_complete();
  endtask

  task automatic do_reset();
    reset = 1'b1;
    for (int n = 0; n < 3; n++) set_m(n, 1'b0, '0);
    bus.sdram_ready    = 1'b0;
    bus.sdram_rdata    = 32'd0;
    bus.sdram_rtag     = 9'd0;
    bus.sdram_rvalid   = 3'b000;
    bus.sdram_complete = 1'b0;
    exp_q.delete(); ref_rd_q.delete(); rsp_q.delete(); cmp_q.delete(); grant_log.delete();
    exp_perr = 1'b0;
    repeat (2) @(posedge clock);
    #1 reset = 1'b0;
    @(posedge clock); #1;
  endtask

  task automatic wait_grants(input int n);
    bit ok = 1'b0;
    for (int t = 0; t < 100 && !ok; t++) begin
      @(negedge clock);
      ok = (grant_log.size() >= n);
    end
    if (!ok) fail("wait_grants_timeout", 64'(grant_log.size()), 64'(n));
    @(posedge clock); #1;
  endtask

  task automatic wait_rd(input int n);
    bit ok = 1'b0;
    for (int t = 0; t < 100 && !ok; t++) begin
      @(negedge clock);
      ok = (ref_rd_q.size() == n);
    end
    if (!ok) fail("wait_reads_timeout", 64'(ref_rd_q.size()), 64'(n));
    @(posedge clock); #1;
  endtask

  task automatic wait_req();
    bit ok = 1'b0;
    for (int t = 0; t < 20 && !ok; t++) begin
      @(negedge clock);
      ok = (bus.sdram_request != 3'b000);
    end
    if (!ok) fail("wait_request_timeout", 64'(bus.sdram_request), 64'd1);
  endtask

  task automatic master_run(input int n, input int cnt);
    for (int i = 0; i < cnt; i++) begin
      repeat ($urandom_range(0, 4)) begin @(posedge clock); #1; end
      send(n, rnd_req(1'($urandom_range(0, 1))));
    end
  endtask

  // Controller-side monitor: every accepted request must be the oldest one its master offered.
  logic [1:0] mon_id;
  bit         mon_ok;
  int         mon_idx;
  req_t       mon_act;
  always @(negedge clock) begin
    if (!reset && bus.sdram_request != 3'b000 && bus.sdram_ready) begin
      mon_ok = 1'b1;
      mon_id = 2'd0;
      case (bus.sdram_request)
        3'b001:  mon_id = 2'd0;
        3'b010:  mon_id = 2'd1;
        3'b100:  mon_id = 2'd2;
        default: begin mon_ok = 1'b0; fail("request_onehot", 64'(bus.sdram_request), 64'd0); end
      endcase
      if (mon_ok) begin
        mon_idx = -1;
        foreach (exp_q[i]) if (mon_idx < 0 && exp_q[i].id == mon_id) mon_idx = i;
        if (mon_idx < 0) fail("grant_unexpected", 64'(bus.sdram_request), 64'd0);
        else begin
          mon_act = {bus.sdram_address, bus.sdram_write, bus.sdram_burst, bus.sdram_wstrb, bus.sdram_wdata};
          chk("grant_fields", mon_act, exp_q[mon_idx].r);
          if (!exp_q[mon_idx].r.w) ref_rd_q.push_back({mon_id, exp_q[mon_idx].r.b});
          exp_q.delete(mon_idx);
          grant_log.push_back(mon_id);
        end
      end
    end
  end

  logic [2:0] rv_act;
  logic [2:0] cp_act;
  rsp_t       rsp_e;
  logic [2:0] cmp_e;
  always @(negedge clock) begin
    if (!reset) begin
      rv_act = {bus.m2_rvalid, bus.m1_rvalid, bus.m0_rvalid};
      cp_act = {bus.m2_complete, bus.m1_complete, bus.m0_complete};
      if (rv_act != 3'b000) begin
        if (rsp_q.size() == 0) fail("rvalid_unexpected", 64'(rv_act), 64'd0);
        else begin
          rsp_e = rsp_q.pop_front();
          chk("rvalid_route", 64'(rv_act), 64'(rsp_e.mask));
          chk("rdata", 64'(bus.m_rdata), 64'(rsp_e.data));
          chk("rtag", 64'(bus.m_rtag), 64'(rsp_e.tag));
        end
      end
      if (rsp_q.size() > 1) fail("rvalid_missing", 64'(rsp_q.size()), 64'd1);
      if (cp_act != 3'b000) begin
        if (cmp_q.size() == 0) fail("complete_unexpected", 64'(cp_act), 64'd0);
        else begin
          cmp_e = cmp_q.pop_front();
          chk("complete_route", 64'(cp_act), 64'(cmp_e));
        end
      end
      if (cmp_q.size() > 1) fail("complete_missing", 64'(cmp_q.size()), 64'd1);
    end
  end

  initial begin
    req_t r;
    reset = 1'b1;
    do_reset();

    @(negedge clock);
    chk("reset_request", 64'(bus.sdram_request), 64'd0);
    chk("reset_ready", 64'({bus.m2_ready, bus.m1_ready, bus.m0_ready}), 64'h7);
    chk("reset_resp", {bus.m2_rvalid, bus.m1_rvalid, bus.m0_rvalid, bus.m2_complete, bus.m1_complete,
                       bus.m0_complete, bus.m_rdata, bus.m_rtag, bus.protocol_error}, 64'd0);
    chk("reset_fields", {bus.sdram_address, bus.sdram_write, bus.sdram_burst, bus.sdram_wstrb, bus.sdram_wdata}, 64'd0);
    @(posedge clock); #1;

    // Single read from m1, exact issue timing.
    bus.sdram_ready = 1'b1;
    send(1, {26'h0001000, 1'b0, 1'b0, 4'hF, 32'h0000005A});
    @(negedge clock); chk("single_req_cycle0", 64'(bus.sdram_request), 64'd0);
    @(negedge clock); chk("single_req_cycle1", 64'(bus.sdram_request), 64'h2);
    @(negedge clock); chk("single_req_cycle2", 64'(bus.sdram_request), 64'd0);
    @(posedge clock); #1;
    pulse_rvalid(3'b010, 32'hDEADBEEF, 9'h05A);
    pulse_complete();
    repeat (3) @(posedge clock); #1;

    // Round-robin from reset: 0,1,2 then 0,2.
    do_reset();
    bus.sdram_ready = 1'b1;
    fork
      send(0, rnd_req(1'b1));
      send(1, rnd_req(1'b1));
      send(2, rnd_req(1'b1));
    join
    wait_grants(3);
    chk("rr_order_012", glog(), 64'h012);
    grant_log.delete();
    fork
      send(0, rnd_req(1'b1));
      send(2, rnd_req(1'b1));
    join
    wait_grants(2);
    chk("rr_order_02", glog(), 64'h02);

    // Stall: fields held while the controller is not ready.
    bus.sdram_ready = 1'b0;
    r = rnd_req(1'b1);
    send(2, r);
    wait_req();
    for (int i = 0; i < 10; i++) begin
      chk("stall_fields", {bus.sdram_address, bus.sdram_write, bus.sdram_burst, bus.sdram_wstrb, bus.sdram_wdata}, r);
      chk("stall_req_rdy", 64'({bus.sdram_request, bus.m2_ready}), 64'({3'b100, 1'b0}));
      @(negedge clock);
    end
    @(posedge clock); #1;
    bus.sdram_ready = 1'b1;
    grant_log.delete();
    wait_grants(1);

    // Read FIFO full: a 5th m0 read waits, an m1 write still goes.
    do_reset();
    bus.sdram_ready = 1'b1;
    for (int i = 0; i < 4; i++) send(0, {26'($urandom), 1'b0, 1'b1, 4'hF, 32'(i)});
    wait_rd(4);
    fork
      send(0, rnd_req(1'b0));
      send(1, rnd_req(1'b1));
    join
    repeat (10) @(negedge clock);
    chk("fifo_full_hold", 64'(ref_rd_q.size()), 64'd4);
    chk("fifo_full_write_passes", glog(), 64'h00001);
    chk("fifo_full_m0_ready", 64'(bus.m0_ready), 64'd0);
    @(posedge clock); #1;
    pulse_complete();
    wait_rd(4);
    chk("fifth_read_order", glog(), 64'h000010);
    repeat (4) pulse_complete();
    repeat (3) @(posedge clock); #1;

    // Completion routing order and protocol errors.
    do_reset();
    bus.sdram_ready = 1'b1;
    send(2, {26'h0002000, 1'b0, 1'b0, 4'hF, 32'h00000111});
    wait_rd(1);
    send(0, {26'h0003000, 1'b0, 1'b0, 4'hF, 32'h00000022});
    wait_rd(2);
    pulse_rvalid(3'b100, 32'h12345678, 9'h111);
    pulse_rvalid(3'b001, 32'h9ABCDEF0, 9'h022);
    pulse_complete();
    pulse_complete();
    repeat (3) @(negedge clock);
    chk("perr_clear", 64'(bus.protocol_error), 64'(exp_perr));
    @(posedge clock); #1;
    pulse_complete();
    repeat (3) @(negedge clock);
    chk("perr_empty_complete", 64'(bus.protocol_error), 64'(exp_perr));
    @(posedge clock); #1;
    do_reset();
    @(negedge clock);
    chk("perr_after_reset", 64'(bus.protocol_error), 64'd0);
    @(posedge clock); #1;
    pulse_rvalid(3'b110, 32'hCAFEF00D, 9'h1FF);
    repeat (2) @(negedge clock);
    chk("perr_multi_rvalid", 64'(bus.protocol_error), 64'd1);
    @(posedge clock); #1;

    // Asynchronous reset while a request is being presented.
    do_reset();
    send(0, rnd_req(1'b1));
    wait_req();
    #2 reset = 1'b1;
    #1 chk("async_reset_req", 64'(bus.sdram_request), 64'd0);
    do_reset();
    @(negedge clock);
    chk("async_reset_ready", 64'({bus.m2_ready, bus.m1_ready, bus.m0_ready}), 64'h7);
    @(posedge clock); #1;

    // Randomized traffic from all three masters against a random controller.
    do_reset();
    rnd_done = 1'b0;
    fork
      begin
        bit idle;
        fork
          master_run(0, 12);
          master_run(1, 12);
          master_run(2, 12);
        join
        idle = 1'b0;
        for (int t = 0; t < 3000 && !idle; t++) begin
          @(negedge clock);
          idle = (exp_q.size() == 0 && ref_rd_q.size() == 0);
        end
        if (!idle) fail("random_drain_timeout", 64'(exp_q.size() + ref_rd_q.size()), 64'd0);
        repeat (3) @(posedge clock); #1;
        rnd_done = 1'b1;
      end
      begin
        while (!rnd_done) begin
          @(posedge clock); #1;
          bus.sdram_ready = ($urandom_range(0, 3) != 0);
        end
      end
      begin
        while (!rnd_done) begin
          if (ref_rd_q.size() != 0 && $urandom_range(0, 1) == 1) respond();
          else begin @(posedge clock); #1; end
        end
      end
    join
    repeat (3) @(negedge clock);
    chk("random_rsp_drained", 64'(rsp_q.size()), 64'd0);
    chk("random_cmp_drained", 64'(cmp_q.size()), 64'd0);
    chk("random_req_drained", 64'(exp_q.size()), 64'd0);
    chk("random_no_perr", 64'(bus.protocol_error), 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
